// File: rtl/us_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : us_ctrl_pkg
//  Description : Shared types and default constants for the ultrasound
//                front-end control path (PIO word serializer).
//  Revision    : 1.0 - initial release
// ============================================================================
package us_ctrl_pkg;

    localparam int SER_WIDTH   = 32;
    localparam int SER_CLK_DIV = 4;

    // Serializer phases: idle, sclk low half, sclk high half, closing gap
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        TAIL = 2'd3
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/pio_word_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pio_word_serializer_if
//  Description : PIO-side word/start inputs and serial link / status outputs
//                of the word serializer. master = host side, slave = block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pio_word_serializer_if
    import us_ctrl_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic             sclk;
    logic             sdo;
    logic             cs_n;
    logic             busy;
    logic             done;

    modport master (
        output data_in, start,
        input  sclk, sdo, cs_n, busy, done
    );

    modport slave (
        input  data_in, start,
        output sclk, sdo, cs_n, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pio_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pio_word_serializer
//  Description : Captures the PIO word on a start rising edge and shifts it
//                out MSB-first on sclk/sdo framed by cs_n; reports busy and
//                a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_word_serializer
    import us_ctrl_pkg::*;
#(
    parameter int WIDTH   = SER_WIDTH,
    parameter int CLK_DIV = SER_CLK_DIV
)(
    input  wire logic            clk,
    input  wire logic            reset,
    pio_word_serializer_if.slave bus
);

    localparam int c_div_w = $clog2(CLK_DIV + 1);
    localparam int c_bit_w = $clog2(WIDTH);
    localparam logic [c_div_w-1:0] c_div_reload = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last   = c_bit_w'(WIDTH - 1);

    ser_state_t         r_state, w_state;
    logic [c_div_w-1:0] r_div_cnt, w_div_cnt;
    logic [c_bit_w-1:0] r_bit_cnt, w_bit_cnt;
    logic [WIDTH-1:0]   r_shift, w_shift;
    logic               r_sclk, w_sclk;
    logic               r_sdo, w_sdo;
    logic               r_cs_n, w_cs_n;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_start_q;
    logic               w_div_end;

    // Start edge detector; resets high so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        if (reset) r_start_q <= 1'b1;
        else       r_start_q <= bus.start;
    end

    // State, counters, shift register and registered link outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_div_cnt <= w_div_cnt;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_sclk    <= w_sclk;
            r_sdo     <= w_sdo;
            r_cs_n    <= w_cs_n;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    // Next-state and datapath: each phase lasts CLK_DIV cycles, the divider
    // reloads on every phase entry and counts down to zero
    always_comb begin
        w_state   = r_state;
        w_div_cnt = r_div_cnt;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_sclk    = r_sclk;
        w_sdo     = r_sdo;
        w_cs_n    = r_cs_n;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_div_end = (r_div_cnt == '0);

        case (r_state)
            IDLE: begin
                if (bus.start && !r_start_q) begin
                    w_state   = LOW;
                    w_div_cnt = c_div_reload;
                    w_bit_cnt = c_bit_last;
                    w_shift   = bus.data_in;
                    w_sdo     = bus.data_in[WIDTH-1];
                    w_sclk    = 1'b0;
                    w_cs_n    = 1'b0;
                    w_busy    = 1'b1;
                end
            end
            LOW: begin
                if (w_div_end) begin
                    w_state   = HIGH;
                    w_div_cnt = c_div_reload;
                    w_sclk    = 1'b1;
                end else begin
                    w_div_cnt = r_div_cnt - c_div_w'(1);
                end
            end
            HIGH: begin
                if (w_div_end) begin
                    // Falling edge: advance to the next bit while sclk is low
                    w_div_cnt = c_div_reload;
                    w_sclk    = 1'b0;
                    w_shift   = r_shift << 1;
                    if (r_bit_cnt == '0) begin
                        w_state = TAIL;
                        w_sdo   = 1'b0;
                    end else begin
                        w_state   = LOW;
                        w_sdo     = r_shift[WIDTH-2];
                        w_bit_cnt = r_bit_cnt - c_bit_w'(1);
                    end
                end else begin
                    w_div_cnt = r_div_cnt - c_div_w'(1);
                end
            end
            TAIL: begin
                if (w_div_end) begin
                    w_state   = IDLE;
                    w_div_cnt = '0;
                    w_cs_n    = 1'b1;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                end else begin
                    w_div_cnt = r_div_cnt - c_div_w'(1);
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.sclk = r_sclk;
    assign bus.sdo  = r_sdo;
    assign bus.cs_n = r_cs_n;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pio_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_word_serializer
//  Description : Self-checking bench for pio_word_serializer; drives one
//                CLK_DIV=4 and one CLK_DIV=1 instance from shared inputs and
//                compares every cycle against a frame-timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_word_serializer;
    import us_ctrl_pkg::*;

    localparam int c_w = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [c_w-1:0] data_in;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pio_word_serializer_if #(.WIDTH(c_w)) u_if4 ();
    pio_word_serializer_if #(.WIDTH(c_w)) u_if1 ();

    assign u_if4.data_in = data_in;
    assign u_if4.start   = start;
    assign u_if1.data_in = data_in;
    assign u_if1.start   = start;

    pio_word_serializer #(.WIDTH(c_w), .CLK_DIV(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if4.slave)
    );

    pio_word_serializer #(.WIDTH(c_w), .CLK_DIV(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if1.slave)
    );

    // {sclk, sdo, cs_n, busy, done} per instance
    logic [4:0] w_act [2];
    assign w_act[0] = {u_if4.sclk, u_if4.sdo, u_if4.cs_n, u_if4.busy, u_if4.done};
    assign w_act[1] = {u_if1.sclk, u_if1.sdo, u_if1.cs_n, u_if1.busy, u_if1.done};

    function automatic int f_div(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Expected outputs t cycles after the accept edge: a frame is 2*WIDTH
    // half-periods of clock plus one quiet half-period, then a done cycle
    function automatic logic [4:0] f_expect(input bit act, input int t, input int dv,
                                            input logic [c_w-1:0] w);
        int   last;
        int   i;
        logic s;
        logic b;
        last = dv * (2 * c_w + 1);
        if (!act || t > last) return 5'b00100;
        if (t == last)        return 5'b00101;
        s = ((t / dv) % 2) == 1;
        i = t / (2 * dv);
        b = (i < c_w) ? w[c_w-1-i] : 1'b0;
        return {s, b, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: accept cycle and captured word per instance
    bit             m_act  [2] = '{1'b0, 1'b0};
    bit             m_prev [2] = '{1'b1, 1'b1};
    int             m_k    [2] = '{0, 0};
    logic [c_w-1:0] m_word [2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d]  <= 1'b0;
                m_prev[d] <= 1'b1;
            end else begin
                m_prev[d] <= start;
                if (start && !m_prev[d] &&
                    (!m_act[d] || (cyc - m_k[d]) > f_div(d) * (2 * c_w + 1))) begin
                    m_act[d]  <= 1'b1;
                    m_k[d]    <= cyc;
                    m_word[d] <= data_in;
                end
            end
        end
    end

    // Frame observers fed from the DUT pins
    logic [c_w-1:0] cap       [2];
    int             rises     [2] = '{0, 0};
    int             fall_cyc  [2] = '{0, 0};
    int             hi_run    [2] = '{0, 0};
    int             last_gap  [2] = '{0, 0};
    logic [c_w-1:0] last_word [2];
    int             last_len  [2] = '{0, 0};
    int             last_rise [2] = '{0, 0};
    int             done_cnt  [2] = '{0, 0};
    logic           prev_sclk [2] = '{1'b0, 1'b0};
    logic           prev_cs   [2] = '{1'b1, 1'b1};
    logic [4:0]     ev;

    // Per-cycle comparison against the model, plus frame observation
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ev = f_expect(m_act[d], cyc - 1 - m_k[d], f_div(d), m_word[d]);
                check($sformatf("div%0d.sclk", f_div(d)), 32'(w_act[d][4]), 32'(ev[4]));
                check($sformatf("div%0d.sdo",  f_div(d)), 32'(w_act[d][3]), 32'(ev[3]));
                check($sformatf("div%0d.cs_n", f_div(d)), 32'(w_act[d][2]), 32'(ev[2]));
                check($sformatf("div%0d.busy", f_div(d)), 32'(w_act[d][1]), 32'(ev[1]));
                check($sformatf("div%0d.done", f_div(d)), 32'(w_act[d][0]), 32'(ev[0]));

                if (!w_act[d][2] && prev_cs[d]) begin
                    cap[d]      <= '0;
                    rises[d]    <= 0;
                    fall_cyc[d] <= cyc;
                    last_gap[d] <= hi_run[d];
                    hi_run[d]   <= 0;
                end else begin
                    if (w_act[d][4] && !prev_sclk[d]) begin
                        cap[d]   <= {cap[d][c_w-2:0], w_act[d][3]};
                        rises[d] <= rises[d] + 1;
                    end
                    if (w_act[d][2]) hi_run[d] <= hi_run[d] + 1;
                end
                if (w_act[d][0]) begin
                    last_word[d] <= cap[d];
                    last_len[d]  <= cyc - fall_cyc[d];
                    last_rise[d] <= rises[d];
                    done_cnt[d]  <= done_cnt[d] + 1;
                end
                prev_sclk[d] <= w_act[d][4];
                prev_cs[d]   <= w_act[d][2];
            end
        end
    end

    task automatic wait_done(input int d, input int budget);
        int n;
        n = 0;
        while (w_act[d][0] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check($sformatf("timeout_done_div%0d", f_div(d)), 32'd0, 32'd1);
    endtask

    int dc;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_cs_n", 32'(u_if4.cs_n), 32'd1);
        check("reset_busy", 32'(u_if4.busy), 32'd0);
        check("reset_sclk", 32'(u_if4.sclk), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame
        data_in = 32'hA5C3_0F81;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_cs_low_at_accept", 32'(u_if4.cs_n), 32'd0);
        wait_done(0, 400);
        repeat (2) @(negedge clk);
        check("t1_word_div4",  last_word[0], 32'hA5C3_0F81);
        check("t1_len_div4",   32'(last_len[0]), 32'd260);
        check("t1_rises_div4", 32'(last_rise[0]), 32'd32);
        check("t1_word_div1",  last_word[1], 32'hA5C3_0F81);
        check("t1_len_div1",   32'(last_len[1]), 32'd65);

        // Second edge mid-frame with data change is ignored
        dc      = done_cnt[0];
        data_in = 32'h1234_5678;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        data_in = 32'h0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 400);
        repeat (20) @(negedge clk);
        check("t2_word_div4",  last_word[0], 32'h1234_5678);
        check("t2_single_done", 32'(done_cnt[0] - dc), 32'd1);

        // Reset mid-frame with start held high
        data_in = 32'hDEAD_BEEF;
        start   = 1'b1;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t3_abort_cs_n", 32'(u_if4.cs_n), 32'd1);
        check("t3_abort_sclk", 32'(u_if4.sclk), 32'd0);
        check("t3_abort_busy", 32'(u_if4.busy), 32'd0);
        check("t3_abort_done", 32'(u_if4.done), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_no_retrigger", 32'(u_if4.busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("t3_new_accept", 32'(u_if4.busy), 32'd1);
        wait_done(0, 400);
        repeat (2) @(negedge clk);
        check("t3_word_div4", last_word[0], 32'hDEAD_BEEF);

        // All-ones word on the fastest divider
        start = 1'b0;
        @(negedge clk);
        data_in = 32'hFFFF_FFFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 100);
        repeat (2) @(negedge clk);
        check("t4_word_div1",  last_word[1], 32'hFFFF_FFFF);
        check("t4_len_div1",   32'(last_len[1]), 32'd65);
        check("t4_rises_div1", 32'(last_rise[1]), 32'd32);
        wait_done(0, 400);
        @(negedge clk);

        // Back-to-back frames
        data_in = 32'h0F0F_1234;
        start   = 1'b1;
        @(negedge clk);
        wait_done(0, 400);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("t5_second_accept", 32'(u_if4.busy), 32'd1);
        wait_done(0, 400);
        repeat (2) @(negedge clk);
        check("t5_gap_div4",  32'(last_gap[0]), 32'd2);
        check("t5_word_div4", last_word[0], 32'h0F0F_1234);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
